riscv_dift_fetch_fifo: RTL and testbench

//   Parametrised instruction prefetch FIFO with per-entry DIFT tag.

---
 rtl/riscv_dift_fetch_fifo_if.sv | 39 +++
 rtl/riscv_dift_fetch_fifo.sv | 118 +++++++++++
 tb/tb_riscv_dift_fetch_fifo.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_dift_fetch_fifo_if.sv
// riscv_dift_fetch_fifo_if: control, instruction-memory and consumer
// signals of the DIFT-tagged prefetch FIFO.
interface riscv_dift_fetch_fifo_if #(
   parameter int TAG_W = 1
);
   logic             req_i;
   logic             branch_i;
   logic [31:0]      branch_addr_i;
   logic [TAG_W-1:0] branch_tag_i;
   logic             instr_req_o;
   logic [31:0]      instr_addr_o;
   logic             instr_gnt_i;
   logic             instr_rvalid_i;
   logic [31:0]      instr_rdata_i;
   logic             valid_o;
   logic             ready_i;
   logic [31:0]      rdata_o;
   logic [31:0]      addr_o;
   logic [TAG_W-1:0] tag_o;
   logic             busy_o;

   modport master (
      input  req_i, branch_i, branch_addr_i, branch_tag_i,
      output instr_req_o, instr_addr_o,
      input  instr_gnt_i, instr_rvalid_i, instr_rdata_i,
      output valid_o,
      input  ready_i,
      output rdata_o, addr_o, tag_o, busy_o
   );

   modport slave (
      output req_i, branch_i, branch_addr_i, branch_tag_i,
      input  instr_req_o, instr_addr_o,
      output instr_gnt_i, instr_rvalid_i, instr_rdata_i,
      input  valid_o,
      output ready_i,
      input  rdata_o, addr_o, tag_o, busy_o
   );
endinterface

// File: rtl/riscv_dift_fetch_fifo.sv
// riscv_dift_fetch_fifo: sequential instruction prefetch buffer with a
// per-entry DIFT tag and post-branch discard of in-flight responses.
module riscv_dift_fetch_fifo #(
   parameter int DEPTH           = 4,
   parameter int MAX_OUTSTANDING = 2,
   parameter int TAG_W           = 1
) (
   input logic                     clk,
   input logic                     rst,
   riscv_dift_fetch_fifo_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int SW = $clog2(DEPTH + MAX_OUTSTANDING + 1);

   typedef enum logic {S_IDLE, S_REQ} state_t;

   state_t           r_state;
   logic [31:0]      r_data [DEPTH];
   logic [31:0]      r_addr [DEPTH];
   logic [TAG_W-1:0] r_tag  [DEPTH];
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic [OW-1:0]    r_out;
   logic [OW-1:0]    r_disc;
   logic [31:0]      r_fetch_addr;
   logic [31:0]      r_resp_addr;
   logic [TAG_W-1:0] r_cur_tag;

   logic          w_credit;
   logic          w_req;
   logic          w_gfire;
   logic          w_push;
   logic          w_pop;
   logic          w_valid;
   logic [OW-1:0] w_out_nxt;
   logic [SW-1:0] w_inflight;
   logic [31:0]   w_baddr;

   assign w_baddr = bus.branch_addr_i & ~32'd3;
   assign w_valid = (r_count != '0);

   // Responses already owed to the old stream do not consume FIFO space.
   assign w_inflight = SW'(r_count) + SW'(r_out) - SW'(r_disc);
   assign w_credit   = (w_inflight < SW'(DEPTH)) &&
                       (r_out < OW'(MAX_OUTSTANDING));

   assign w_req   = (r_state == S_REQ) && bus.req_i &&
                    !bus.branch_i && w_credit;
   assign w_gfire = w_req && bus.instr_gnt_i;
   assign w_push  = bus.instr_rvalid_i && (r_disc == '0) &&
                    !bus.branch_i;
   assign w_pop   = w_valid && bus.ready_i && !bus.branch_i;

   assign w_out_nxt = r_out + OW'(w_gfire) - OW'(bus.instr_rvalid_i);

   assign bus.instr_req_o  = w_req;
   assign bus.instr_addr_o = r_fetch_addr;
   assign bus.valid_o      = w_valid;
   assign bus.rdata_o      = w_valid ? r_data[r_rptr] : '0;
   assign bus.addr_o       = w_valid ? r_addr[r_rptr] : '0;
   assign bus.tag_o        = w_valid ? r_tag[r_rptr] : '0;
   assign bus.busy_o       = (r_out != '0) || w_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
         r_out        <= '0;
         r_disc       <= '0;
         r_fetch_addr <= '0;
         r_resp_addr  <= '0;
         r_cur_tag    <= '0;
      end else begin
         unique case (r_state)
            S_IDLE:  if (bus.req_i) r_state <= S_REQ;
            S_REQ:   if (!bus.req_i) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
         r_out <= w_out_nxt;
         if (bus.branch_i) begin
            r_fetch_addr <= w_baddr;
            r_resp_addr  <= w_baddr;
            r_cur_tag    <= bus.branch_tag_i;
            r_disc       <= w_out_nxt;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
         end else begin
            if (w_gfire) r_fetch_addr <= r_fetch_addr + 32'd4;
            if (bus.instr_rvalid_i && (r_disc != '0))
               r_disc <= r_disc - OW'(1);
            if (w_push) begin
               r_resp_addr <= r_resp_addr + 32'd4;
               r_wptr      <= r_wptr + PW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop) r_count <= r_count + CW'(1);
            if (!w_push && w_pop) r_count <= r_count - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_data[r_wptr] <= bus.instr_rdata_i;
         r_addr[r_wptr] <= r_resp_addr;
         r_tag[r_wptr]  <= r_cur_tag;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(w_push && !w_pop && (r_count == CW'(DEPTH))));
endmodule

// File: tb/tb_riscv_dift_fetch_fifo.sv
// tb_riscv_dift_fetch_fifo: vector table, hand sequences and an
// entry scoreboard for the DIFT-tagged prefetch FIFO.
module tb_riscv_dift_fetch_fifo;
   localparam int DEPTH = 4;
   localparam int MO    = 2;
   localparam int TW    = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   riscv_dift_fetch_fifo_if #(.TAG_W(TW)) bus ();

   riscv_dift_fetch_fifo #(
      .DEPTH(DEPTH),
      .MAX_OUTSTANDING(MO),
      .TAG_W(TW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } mrec_t;

   typedef struct {
      logic [31:0]   d;
      logic [31:0]   a;
      logic [TW-1:0] t;
   } ent_t;

   typedef struct {
      logic [31:0]   baddr;
      logic [TW-1:0] tag;
      logic [31:0]   first;
      logic [31:0]   second;
   } vec_t;

   mrec_t         mq[$];
   ent_t          sb[$];
   logic [31:0]   ovr[$];
   logic          lat0 = 1'b1;
   logic          gnt_en = 1'b1;
   logic          rv_en = 1'b1;
   logic          hv = 1'b0;
   logic [31:0]   hd = '0;
   logic [TW-1:0] cur_tag = '0;
   int            total = 0;
   int            bad = 0;

   function automatic logic [31:0] mf(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   // lat0: zero-wait memory; otherwise one-cycle in-order responder
   assign bus.instr_gnt_i    = gnt_en;
   assign bus.instr_rvalid_i = lat0 ? (bus.instr_req_o & gnt_en)
                                    : (hv & rv_en);
   assign bus.instr_rdata_i  = lat0 ? mf(bus.instr_addr_o) : hd;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, act, exp);
      end
   endtask

   always begin : mon
      logic        g;
      logic        r;
      logic        rs;
      logic [31:0] ga;
      ent_t        e;
      mrec_t       m;
      @(negedge clk);
      rs = rst;
      g  = bus.instr_req_o & bus.instr_gnt_i;
      r  = bus.instr_rvalid_i;
      ga = bus.instr_addr_o;
      if (rs) begin
         sb.delete();
         cur_tag = '0;
      end else begin
         if (bus.valid_o && bus.ready_i && !bus.branch_i) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL sb_pop: got entry @%h want none",
                        bus.addr_o);
            end else begin
               e = sb.pop_front();
               if (bus.rdata_o !== e.d || bus.addr_o !== e.a ||
                   bus.tag_o !== e.t) begin
                  bad++;
                  $display("FAIL sb_pop: got %h@%h/%h want %h@%h/%h",
                           bus.rdata_o, bus.addr_o, bus.tag_o,
                           e.d, e.a, e.t);
               end
            end
         end
         if (bus.branch_i) begin
            sb.delete();
            cur_tag = bus.branch_tag_i;
         end else if (g) begin
            e.d = mf(ga);
            e.a = ga;
            e.t = cur_tag;
            sb.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      if (rs) begin
         mq.delete();
      end else if (!lat0) begin
         if (r) void'(mq.pop_front());
         if (g) begin
            m.a = ga;
            m.d = mf(ga);
            if (ovr.size() != 0) m.d = ovr.pop_front();
            mq.push_back(m);
         end
      end
      hv = (mq.size() != 0);
      hd = hv ? mq[0].d : '0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic branch(input logic [31:0] a, input logic [TW-1:0] t);
      tick();
      bus.branch_i      = 1'b1;
      bus.branch_addr_i = a;
      bus.branch_tag_i  = t;
   endtask

   task automatic wait_valid(input string n, input int budget);
      int k;
      k = 0;
      neg();
      while (!bus.valid_o && k < budget) begin
         neg();
         k++;
      end
      chk(n, 32'(bus.valid_o), 32'd1);
   endtask

   task automatic drain();
      int k;
      k = 0;
      tick();
      bus.req_i = 1'b0;
      rv_en     = 1'b1;
      gnt_en    = 1'b1;
      neg();
      while (bus.busy_o && k < 20) begin
         neg();
         k++;
      end
      chk("drain_busy", 32'(bus.busy_o), 32'd0);
   endtask

   task automatic chk_reset(input string n);
      chk({n, "_valid"}, 32'(bus.valid_o), 32'd0);
      chk({n, "_rdata"}, bus.rdata_o, 32'd0);
      chk({n, "_addr"}, bus.addr_o, 32'd0);
      chk({n, "_tag"}, 32'(bus.tag_o), 32'd0);
      chk({n, "_req"}, 32'(bus.instr_req_o), 32'd0);
      chk({n, "_busy"}, 32'(bus.busy_o), 32'd0);
      chk({n, "_iaddr"}, bus.instr_addr_o, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin : main
      vec_t vt[4];
      int   ng;
      int   np;
      vt[0] = '{32'h0000_0100, 1'b1, 32'h0000_0100, 32'h0000_0104};
      vt[1] = '{32'h0000_0203, 1'b0, 32'h0000_0200, 32'h0000_0204};
      vt[2] = '{32'h0000_0003, 1'b1, 32'h0000_0000, 32'h0000_0004};
      vt[3] = '{32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000};

      bus.req_i         = 1'b0;
      bus.branch_i      = 1'b0;
      bus.branch_addr_i = '0;
      bus.branch_tag_i  = '0;
      bus.ready_i       = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      neg();
      chk_reset("reset");

      // branch table on zero-wait memory
      tick();
      bus.req_i   = 1'b1;
      bus.ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         branch(vt[i].baddr, vt[i].tag);
         neg();
         chk("br_req_masked", 32'(bus.instr_req_o), 32'd0);
         tick();
         bus.branch_i = 1'b0;
         neg();
         chk("first_iaddr", bus.instr_addr_o, vt[i].first);
         chk("first_empty", 32'(bus.valid_o), 32'd0);
         tick();
         neg();
         chk("valid_2cyc", 32'(bus.valid_o), 32'd1);
         chk("head_addr", bus.addr_o, vt[i].first);
         chk("head_tag", 32'(bus.tag_o), 32'(vt[i].tag));
         chk("second_iaddr", bus.instr_addr_o, vt[i].second);
         repeat (5) tick();
      end

      // credit limit with consumer stalled
      drain();
      tick();
      lat0        = 1'b0;
      bus.ready_i = 1'b0;
      bus.req_i   = 1'b1;
      branch(32'h400, 1'b1);
      tick();
      bus.branch_i = 1'b0;
      ng = 0;
      for (int k = 0; k < 12; k++) begin
         neg();
         if (bus.instr_req_o && bus.instr_gnt_i) ng++;
      end
      chk("credit_grants", 32'(ng), 32'd4);
      chk("credit_req_low", 32'(bus.instr_req_o), 32'd0);
      chk("credit_full_valid", 32'(bus.valid_o), 32'd1);
      tick();
      bus.ready_i = 1'b1;
      neg();
      chk("pop_cycle_req", 32'(bus.instr_req_o), 32'd0);
      tick();
      neg();
      chk("after_pop_req", 32'(bus.instr_req_o), 32'd1);
      chk("after_pop_iaddr", bus.instr_addr_o, 32'h410);
      repeat (4) tick();

      // stale responses after a flush are discarded
      drain();
      tick();
      ovr.push_back(32'h0000_DEAD);
      ovr.push_back(32'h0000_BEEF);
      rv_en       = 1'b0;
      bus.req_i   = 1'b1;
      bus.branch_i      = 1'b1;
      bus.branch_addr_i = 32'h600;
      bus.branch_tag_i  = 1'b1;
      tick();
      bus.branch_i = 1'b0;
      repeat (3) tick();
      bus.branch_i      = 1'b1;
      bus.branch_addr_i = 32'h200;
      bus.branch_tag_i  = 1'b0;
      neg();
      chk("stale_busy", 32'(bus.busy_o), 32'd1);
      tick();
      bus.branch_i = 1'b0;
      neg();
      chk("stale_blocks_req", 32'(bus.instr_req_o), 32'd0);
      tick();
      rv_en = 1'b1;
      wait_valid("stale_new_valid", 20);
      chk("stale_head_addr", bus.addr_o, 32'h200);
      chk("stale_head_tag", 32'(bus.tag_o), 32'd0);
      chk("stale_head_data", bus.rdata_o, mf(32'h200));

      // branch colliding with rvalid and pop
      repeat (6) tick();
      bus.branch_i      = 1'b1;
      bus.branch_addr_i = 32'h900;
      bus.branch_tag_i  = 1'b1;
      neg();
      chk("coll_valid", 32'(bus.valid_o), 32'd1);
      chk("coll_rvalid", 32'(bus.instr_rvalid_i), 32'd1);
      tick();
      bus.branch_i = 1'b0;
      neg();
      chk("coll_flushed", 32'(bus.valid_o), 32'd0);
      wait_valid("coll_new_valid", 20);
      chk("coll_head_addr", bus.addr_o, 32'h900);
      chk("coll_head_tag", 32'(bus.tag_o), 32'd1);
      chk("coll_head_data", bus.rdata_o, mf(32'h900));

      // grant withheld: address must hold
      drain();
      tick();
      lat0   = 1'b1;
      gnt_en = 1'b0;
      bus.req_i = 1'b1;
      branch(32'hA00, 1'b1);
      tick();
      bus.branch_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         neg();
         chk("nognt_iaddr", bus.instr_addr_o, 32'hA00);
         chk("nognt_req", 32'(bus.instr_req_o), 32'd1);
      end
      tick();
      gnt_en = 1'b1;
      repeat (6) tick();

      // req dropped with two requests outstanding
      drain();
      tick();
      lat0  = 1'b0;
      rv_en = 1'b0;
      bus.req_i = 1'b1;
      branch(32'hB00, 1'b0);
      tick();
      bus.branch_i = 1'b0;
      repeat (3) tick();
      bus.req_i = 1'b0;
      neg();
      chk("reqoff_req", 32'(bus.instr_req_o), 32'd0);
      chk("reqoff_busy", 32'(bus.busy_o), 32'd1);
      tick();
      rv_en = 1'b1;
      np = 0;
      for (int k = 0; k < 8; k++) begin
         neg();
         if (bus.valid_o && bus.ready_i) np++;
      end
      chk("reqoff_pushed", 32'(np), 32'd2);
      chk("reqoff_busy_low", 32'(bus.busy_o), 32'd0);

      // reset in the middle of a stream
      tick();
      bus.req_i = 1'b1;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      neg();
      chk_reset("midrst");
      tick();
      neg();
      chk("midrst_restart_req", 32'(bus.instr_req_o), 32'd1);
      chk("midrst_restart_addr", bus.instr_addr_o, 32'd0);
      repeat (6) tick();
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
